codec_sequencer: RTL and testbench

Sequences bring-up of the audio codec and its serial interface, then schedules per-frame sample exchange between the codec interface and the DSP core. Holds codec reset, waits for the clocks to settle, aligns to the first valid frame, and runs. In run, it hands each captured stereo sample to the core and returns the core's result to the interface before the next frame. It detects lost frames and late core results, and recovers from both.

---
 rtl/codec_sequencer.sv | 122 ++++++++++++
 tb/tb_codec_sequencer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/codec_sequencer.sv
// codec_sequencer: codec bring-up sequencer and per-frame sample exchange with the DSP core (UNDERRUN_BYPASS_EN: replay dry input on underrun)
module codec_sequencer #(
   parameter int RST_HOLD_CYC = 1024,
   parameter int WARMUP_CYC   = 4096,
   parameter int FRAME_TO_CYC = 2048,
   parameter int CNT_W        = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic        VALID,
   input  logic [15:0] left_in,
   input  logic [15:0] right_in,
   input  logic [15:0] core_left,
   input  logic [15:0] core_right,
   input  logic        core_vld,
   output logic        RST_n,
   output logic        if_en,
   output logic [15:0] smpl_left,
   output logic [15:0] smpl_right,
   output logic        smpl_rdy,
   output logic [15:0] left_out,
   output logic [15:0] right_out,
   output logic [1:0]  state,
   output logic [7:0]  underrun_cnt,
   output logic [7:0]  resync_cnt
);
   typedef enum logic [1:0] {RESET_HOLD, WARMUP, SYNC, RUN} state_t;
   state_t           state_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pend_q, rstn_q, ifen_q, rdy_q;
   logic [15:0]      sl_q, sr_q, lo_q, ro_q, uf_l, uf_r;
   logic [7:0]       und_q, und_d, res_q, res_d;
   assign cnt_d = cnt_q + 1'b1;
   assign und_d = (und_q == 8'hFF) ? und_q : und_q + 8'd1;
   assign res_d = (res_q == 8'hFF) ? res_q : res_q + 8'd1;
`ifdef UNDERRUN_BYPASS_EN
   assign uf_l = sl_q;
   assign uf_r = sr_q;
`else
   assign uf_l = '0;
   assign uf_r = '0;
`endif
   assign RST_n        = rstn_q;
   assign if_en        = ifen_q;
   assign smpl_left    = sl_q;
   assign smpl_right   = sr_q;
   assign smpl_rdy     = rdy_q;
   assign left_out     = lo_q;
   assign right_out    = ro_q;
   assign state        = state_q;
   assign underrun_cnt = und_q;
   assign resync_cnt   = res_q;
   // Sequencer FSM; codec controls follow the state one cycle later, frame exchange runs in SYNC/RUN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RESET_HOLD;
         cnt_q   <= '0;
         pend_q  <= 1'b0;
         rstn_q  <= 1'b0;
         ifen_q  <= 1'b0;
         rdy_q   <= 1'b0;
         sl_q    <= '0;
         sr_q    <= '0;
         lo_q    <= '0;
         ro_q    <= '0;
         und_q   <= '0;
         res_q   <= '0;
      end else begin
         rstn_q <= state_q != RESET_HOLD;
         ifen_q <= state_q == SYNC || state_q == RUN;
         rdy_q  <= 1'b0;
         if (!en) begin
            state_q <= RESET_HOLD;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            lo_q    <= '0;
            ro_q    <= '0;
         end else begin
            case (state_q)
               RESET_HOLD: begin
                  cnt_q <= (cnt_q == CNT_W'(RST_HOLD_CYC - 1)) ? '0 : cnt_d;
                  if (cnt_q == CNT_W'(RST_HOLD_CYC - 1)) state_q <= WARMUP;
               end
               WARMUP: begin
                  cnt_q <= (cnt_q == CNT_W'(WARMUP_CYC - 1)) ? '0 : cnt_d;
                  if (cnt_q == CNT_W'(WARMUP_CYC - 1)) state_q <= SYNC;
               end
               default: begin
                  if (core_vld && pend_q) begin
                     lo_q   <= core_left;
                     ro_q   <= core_right;
                     pend_q <= 1'b0;
                  end
                  if (VALID) begin
                     state_q <= RUN;
                     cnt_q   <= '0;
                     sl_q    <= left_in;
                     sr_q    <= right_in;
                     rdy_q   <= 1'b1;
                     pend_q  <= 1'b1;
                     if (pend_q && !core_vld) begin
                        und_q <= und_d;
                        lo_q  <= uf_l;
                        ro_q  <= uf_r;
                     end
                  end else if (cnt_q == CNT_W'(FRAME_TO_CYC - 1)) begin
                     state_q <= RESET_HOLD;
                     cnt_q   <= '0;
                     res_q   <= res_d;
                     pend_q  <= 1'b0;
                     lo_q    <= '0;
                     ro_q    <= '0;
                  end else begin
                     cnt_q <= cnt_d;
                  end
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_codec_sequencer.sv
// tb_codec_sequencer: scoreboard bench for codec_sequencer bring-up, frame exchange, underrun, timeout and enable drop
module tb_codec_sequencer;
   logic        clk = 1'b0, rst_n = 1'b0, en = 1'b0, VALID = 1'b0, core_vld = 1'b0;
   logic [15:0] left_in = '0, right_in = '0, core_left = '0, core_right = '0;
   logic        RST_n, if_en, smpl_rdy;
   logic [15:0] smpl_left, smpl_right, left_out, right_out;
   logic [1:0]  state;
   logic [7:0]  underrun_cnt, resync_cnt;

   codec_sequencer dut (
      .clk(clk), .rst_n(rst_n), .en(en), .VALID(VALID), .left_in(left_in), .right_in(right_in),
      .core_left(core_left), .core_right(core_right), .core_vld(core_vld), .RST_n(RST_n), .if_en(if_en),
      .smpl_left(smpl_left), .smpl_right(smpl_right), .smpl_rdy(smpl_rdy), .left_out(left_out),
      .right_out(right_out), .state(state), .underrun_cnt(underrun_cnt), .resync_cnt(resync_cnt)
   );

   always #10 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   localparam int F_ST = 0, F_RSTN = 1, F_IFEN = 2, F_LO = 3, F_RO = 4, F_UND = 5, F_RES = 6;
   typedef struct {int at; int f; logic [15:0] v;} exp_t;
   typedef struct {int at; logic [15:0] l; logic [15:0] r;} smp_t;
   exp_t eq[$];
   smp_t sq[$];
   int tests = 0, fails = 0;

`ifdef UNDERRUN_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   function automatic string fname(int f);
      case (f)
         F_ST:    return "state";
         F_RSTN:  return "RST_n";
         F_IFEN:  return "if_en";
         F_LO:    return "left_out";
         F_RO:    return "right_out";
         F_UND:   return "underrun_cnt";
         default: return "resync_cnt";
      endcase
   endfunction

   function automatic logic [15:0] act(int f);
      case (f)
         F_ST:    return {14'b0, state};
         F_RSTN:  return {15'b0, RST_n};
         F_IFEN:  return {15'b0, if_en};
         F_LO:    return left_out;
         F_RO:    return right_out;
         F_UND:   return {8'b0, underrun_cnt};
         default: return {8'b0, resync_cnt};
      endcase
   endfunction

   task automatic expect_at(input int at, input int f, input int v);
      eq.push_back('{at, f, 16'(v)});
   endtask

   task automatic push_frame(input int e, input logic [15:0] l, input logic [15:0] r);
      sq.push_back('{e, l, r});
      expect_at(e, F_ST, 3);
   endtask

   // monitor: compare due scoreboard entries and every smpl_rdy pulse
   always @(negedge clk) begin
      smp_t s;
      for (int i = eq.size() - 1; i >= 0; i--) begin
         if (eq[i].at == cyc) begin
            tests++;
            if (act(eq[i].f) !== eq[i].v) begin
               fails++;
               $display("FAIL %s @cyc %0d: got %h want %h", fname(eq[i].f), cyc, act(eq[i].f), eq[i].v);
            end
            eq.delete(i);
         end
      end
      while (sq.size() > 0 && sq[0].at < cyc) begin
         tests++;
         fails++;
         $display("FAIL smpl_rdy missing: got none want pulse @cyc %0d", sq[0].at);
         void'(sq.pop_front());
      end
      if (smpl_rdy) begin
         tests++;
         if (sq.size() == 0) begin
            fails++;
            $display("FAIL smpl_rdy unexpected @cyc %0d: got 1 want 0", cyc);
         end else begin
            s = sq.pop_front();
            if (s.at != cyc || smpl_left !== s.l || smpl_right !== s.r) begin
               fails++;
               $display("FAIL smpl @cyc %0d: got %h/%h want %h/%h @cyc %0d", cyc, smpl_left, smpl_right, s.l, s.r, s.at);
            end
         end
      end
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) step();
   endtask

   task automatic drive(input bit v, input logic [15:0] l, input logic [15:0] r,
                        input bit c, input logic [15:0] cl, input logic [15:0] cr);
      VALID = v; left_in = l; right_in = r;
      core_vld = c; core_left = cl; core_right = cr;
      step();
      VALID = 1'b0; core_vld = 1'b0;
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int r0, e1, e2, e3, e4, e5, e6, e7, c, d, s;
      repeat (3) step();
      r0 = cyc;
      for (int f = F_ST; f <= F_RES; f++) expect_at(r0, f, 0);
      rst_n = 1'b1;
      en = 1'b1;
      expect_at(r0 + 1023, F_ST, 0);
      expect_at(r0 + 1024, F_ST, 1);
      expect_at(r0 + 1024, F_RSTN, 0);
      expect_at(r0 + 1025, F_RSTN, 1);
      expect_at(r0 + 5119, F_ST, 1);
      expect_at(r0 + 5120, F_ST, 2);
      expect_at(r0 + 5120, F_IFEN, 0);
      expect_at(r0 + 5121, F_IFEN, 1);
      wait_until(r0 + 5130);
      e1 = cyc + 1;
      push_frame(e1, 16'h1234, 16'hABCD);
      expect_at(e1, F_LO, 0);
      expect_at(e1, F_UND, 0);
      drive(1, 16'h1234, 16'hABCD, 0, 16'h0, 16'h0);
      wait_until(e1 + 100);
      c = cyc + 1;
      expect_at(c - 1, F_LO, 0);
      expect_at(c, F_LO, 16'h1111);
      expect_at(c, F_RO, 16'h2222);
      drive(0, 16'h0, 16'h0, 1, 16'h1111, 16'h2222);
      wait_until(e1 + 1023);
      e2 = cyc + 1;
      push_frame(e2, 16'h5555, 16'h6666);
      expect_at(e2, F_LO, 16'h1111);
      expect_at(e2, F_UND, 0);
      drive(1, 16'h5555, 16'h6666, 0, 16'h0, 16'h0);
      wait_until(e2 + 1023);
      e3 = cyc + 1;
      push_frame(e3, 16'h7777, 16'h8888);
      expect_at(e3, F_UND, 1);
      expect_at(e3, F_LO, BYP ? 16'h5555 : 16'h0);
      expect_at(e3, F_RO, BYP ? 16'h6666 : 16'h0);
      drive(1, 16'h7777, 16'h8888, 0, 16'h0, 16'h0);
      wait_until(e3 + 1023);
      e4 = cyc + 1;
      push_frame(e4, 16'hBBBB, 16'hCCCC);
      expect_at(e4, F_LO, 16'h9999);
      expect_at(e4, F_RO, 16'hAAAA);
      expect_at(e4, F_UND, 1);
      drive(1, 16'hBBBB, 16'hCCCC, 1, 16'h9999, 16'hAAAA);
      wait_until(e4 + 100);
      c = cyc + 1;
      expect_at(c, F_LO, 16'h1357);
      expect_at(c, F_RO, 16'h2468);
      drive(0, 16'h0, 16'h0, 1, 16'h1357, 16'h2468);
      wait_until(e4 + 1023);
      e5 = cyc + 1;
      push_frame(e5, 16'h0102, 16'h0304);
      expect_at(e5, F_UND, 1);
      expect_at(e5, F_LO, 16'h1357);
      drive(1, 16'h0102, 16'h0304, 0, 16'h0, 16'h0);
      wait_until(e5 + 100);
      c = cyc + 1;
      expect_at(c, F_LO, 16'hDEAD);
      expect_at(c, F_RO, 16'hBEEF);
      drive(0, 16'h0, 16'h0, 1, 16'hDEAD, 16'hBEEF);
      wait_until(e5 + 200);
      c = cyc + 1;
      expect_at(c, F_LO, 16'hDEAD);
      expect_at(c, F_RO, 16'hBEEF);
      expect_at(c, F_UND, 1);
      drive(0, 16'h0, 16'h0, 1, 16'hFFFF, 16'hFFFF);
      expect_at(e5 + 2047, F_ST, 3);
      expect_at(e5 + 2047, F_RES, 0);
      expect_at(e5 + 2048, F_ST, 0);
      expect_at(e5 + 2048, F_RES, 1);
      expect_at(e5 + 2048, F_LO, 0);
      expect_at(e5 + 2048, F_RSTN, 1);
      expect_at(e5 + 2049, F_RSTN, 0);
      expect_at(e5 + 2049, F_IFEN, 0);
      expect_at(e5 + 3072, F_ST, 1);
      expect_at(e5 + 3073, F_RSTN, 1);
      expect_at(e5 + 7168, F_ST, 2);
      wait_until(e5 + 7200);
      e6 = cyc + 1;
      push_frame(e6, 16'h0A0A, 16'h0B0B);
      drive(1, 16'h0A0A, 16'h0B0B, 0, 16'h0, 16'h0);
      wait_until(e6 + 50);
      c = cyc + 1;
      expect_at(c, F_LO, 16'h4242);
      expect_at(c, F_RO, 16'h2424);
      drive(0, 16'h0, 16'h0, 1, 16'h4242, 16'h2424);
      wait_until(e6 + 1023);
      e7 = cyc + 1;
      push_frame(e7, 16'h0C0C, 16'h0D0D);
      expect_at(e7, F_UND, 1);
      drive(1, 16'h0C0C, 16'h0D0D, 0, 16'h0, 16'h0);
      wait_until(e7 + 10);
      d = cyc + 1;
      expect_at(d, F_ST, 0);
      expect_at(d, F_LO, 0);
      expect_at(d, F_RO, 0);
      expect_at(d, F_RSTN, 1);
      expect_at(d + 1, F_RSTN, 0);
      expect_at(d, F_IFEN, 1);
      expect_at(d + 1, F_IFEN, 0);
      expect_at(d, F_UND, 1);
      expect_at(d, F_RES, 1);
      en = 1'b0;
      step();
      wait_until(d + 4);
      s = cyc + 1;
      expect_at(s, F_LO, 0);
      expect_at(s, F_RO, 0);
      expect_at(s, F_UND, 1);
      expect_at(s, F_ST, 0);
      drive(0, 16'h0, 16'h0, 1, 16'h7777, 16'h7777);
      wait_until(s + 5);
      @(negedge clk);
      #1;
      foreach (eq[i]) begin
         tests++;
         fails++;
         $display("FAIL %s never checked: got none want %h @cyc %0d", fname(eq[i].f), eq[i].v, eq[i].at);
      end
      foreach (sq[i]) begin
         tests++;
         fails++;
         $display("FAIL smpl_rdy missing: got none want pulse @cyc %0d", sq[i].at);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
